// File: rtl/pipe_ctrl_carrier_if.sv
// Control-carrier bus: decoder-side control/address bundle in, per-stage
// control fan-out, stall and forwarding selects out.
// Ports (slave view): id_ex[2:0] id_m[2:0] id_wb[1:0] id_rs/rt/rd id_valid
//   flush mem_wait in; stall_out ex_* mem_* wb_* fwd_a fwd_b out.
interface pipe_ctrl_carrier_if #(
    parameter int RA_W = 5
);
    logic [2:0]      id_ex;
    logic [2:0]      id_m;
    logic [1:0]      id_wb;
    logic [RA_W-1:0] id_rs;
    logic [RA_W-1:0] id_rt;
    logic [RA_W-1:0] id_rd;
    logic            id_valid;
    logic            flush;
    logic            mem_wait;

    logic            stall_out;
    logic            ex_regdst;
    logic            ex_aluop;
    logic            ex_alusrc;
    logic [RA_W-1:0] ex_rs;
    logic [RA_W-1:0] ex_rt;
    logic [RA_W-1:0] ex_dest;
    logic            mem_branch;
    logic            mem_memread;
    logic            mem_memwrite;
    logic [RA_W-1:0] mem_dest;
    logic            wb_regwrite;
    logic            wb_memtoreg;
    logic [RA_W-1:0] wb_dest;
    logic [1:0]      fwd_a;
    logic [1:0]      fwd_b;

    modport master (
        output id_ex, id_m, id_wb, id_rs, id_rt, id_rd,
        output id_valid, flush, mem_wait,
        input  stall_out, ex_regdst, ex_aluop, ex_alusrc,
        input  ex_rs, ex_rt, ex_dest,
        input  mem_branch, mem_memread, mem_memwrite, mem_dest,
        input  wb_regwrite, wb_memtoreg, wb_dest,
        input  fwd_a, fwd_b
    );

    modport slave (
        input  id_ex, id_m, id_wb, id_rs, id_rt, id_rd,
        input  id_valid, flush, mem_wait,
        output stall_out, ex_regdst, ex_aluop, ex_alusrc,
        output ex_rs, ex_rt, ex_dest,
        output mem_branch, mem_memread, mem_memwrite, mem_dest,
        output wb_regwrite, wb_memtoreg, wb_dest,
        output fwd_a, fwd_b
    );
endinterface

// File: rtl/pipe_ctrl_carrier.sv
// Carries decoded control through ID/EX, EX/MEM, MEM/WB; RAW stall,
// branch flush and memory freeze. Optional macro FORWARD_EN enables
// forwarding selects and limits stalls to load-use.
// Ports: clk, rst (sync, active high), bus (pipe_ctrl_carrier_if.slave).
module pipe_ctrl_carrier #(
    parameter int RA_W = 5
) (
    input logic                 clk,
    input logic                 rst,
    pipe_ctrl_carrier_if.slave  bus
);

    typedef struct packed {
        logic            v;
        logic            regdst;
        logic            aluop;
        logic            alusrc;
        logic            branch;
        logic            memread;
        logic            memwrite;
        logic            regwrite;
        logic            memtoreg;
        logic [RA_W-1:0] rs;
        logic [RA_W-1:0] rt;
        logic [RA_W-1:0] rd;
    } idex_t;

    typedef struct packed {
        logic            v;
        logic            branch;
        logic            memread;
        logic            memwrite;
        logic            regwrite;
        logic            memtoreg;
        logic [RA_W-1:0] dest;
    } exmem_t;

    typedef struct packed {
        logic            v;
        logic            regwrite;
        logic            memtoreg;
        logic [RA_W-1:0] dest;
    } memwb_t;

    idex_t  idex_q,  idex_d,  id_load;
    exmem_t exmem_q, exmem_d;
    memwb_t memwb_q, memwb_d;

    logic [RA_W-1:0] ex_dest_w;
    logic            wr_ex;
    logic            wr_mem;
    logic            dep_ex;
    logic            hazard;

    // Control bits are masked at load so an invalid stage carries zeros.
    always_comb begin
        id_load    = '0;
        id_load.v  = bus.id_valid;
        id_load.rs = bus.id_rs;
        id_load.rt = bus.id_rt;
        id_load.rd = bus.id_rd;
        if (bus.id_valid) begin
            {id_load.regdst, id_load.aluop, id_load.alusrc} = bus.id_ex;
            {id_load.branch, id_load.memread, id_load.memwrite} = bus.id_m;
            {id_load.regwrite, id_load.memtoreg} = bus.id_wb;
        end
    end

    assign ex_dest_w = idex_q.regdst ? idex_q.rd : idex_q.rt;

    // Writes to $0 are discarded, so they never create a dependency.
    assign wr_ex  = idex_q.v & idex_q.regwrite & (|ex_dest_w);
    assign wr_mem = exmem_q.v & exmem_q.regwrite & (|exmem_q.dest);

    assign dep_ex = wr_ex & bus.id_valid &
                    ((ex_dest_w == bus.id_rs) |
                     (ex_dest_w == bus.id_rt));

`ifdef FORWARD_EN
    logic wr_wb;

    assign wr_wb = memwb_q.v & memwb_q.regwrite & (|memwb_q.dest);

    // Only a load still in EX cannot be forwarded in time.
    assign hazard = dep_ex & idex_q.memread;

    function automatic logic [1:0] fwd_sel(
        input logic [RA_W-1:0] a
    );
        if (wr_mem && exmem_q.dest == a)
            return 2'b10;
        else if (wr_wb && memwb_q.dest == a)
            return 2'b01;
        return 2'b00;
    endfunction

    assign bus.fwd_a = fwd_sel(idex_q.rs);
    assign bus.fwd_b = fwd_sel(idex_q.rt);
`else
    logic dep_mem;

    // WB needs no stall: the register file writes before it reads.
    assign dep_mem = wr_mem & bus.id_valid &
                     ((exmem_q.dest == bus.id_rs) |
                      (exmem_q.dest == bus.id_rt));

    assign hazard    = dep_ex | dep_mem;
    assign bus.fwd_a = 2'b00;
    assign bus.fwd_b = 2'b00;
`endif

    // A flush already replaces ID/EX with a bubble, so it suppresses stall.
    assign bus.stall_out = bus.mem_wait | (~bus.flush & hazard);

    always_comb begin
        idex_d  = idex_q;
        exmem_d = exmem_q;
        memwb_d = memwb_q;
        if (!bus.mem_wait) begin
            memwb_d.v        = exmem_q.v;
            memwb_d.regwrite = exmem_q.regwrite;
            memwb_d.memtoreg = exmem_q.memtoreg;
            memwb_d.dest     = exmem_q.dest;

            exmem_d.v        = idex_q.v;
            exmem_d.branch   = idex_q.branch;
            exmem_d.memread  = idex_q.memread;
            exmem_d.memwrite = idex_q.memwrite;
            exmem_d.regwrite = idex_q.regwrite;
            exmem_d.memtoreg = idex_q.memtoreg;
            exmem_d.dest     = ex_dest_w;
            if (bus.flush)
                exmem_d = '0;

            if (bus.flush || hazard)
                idex_d = '0;
            else
                idex_d = id_load;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idex_q  <= '0;
            exmem_q <= '0;
            memwb_q <= '0;
        end else begin
            idex_q  <= idex_d;
            exmem_q <= exmem_d;
            memwb_q <= memwb_d;
        end
    end

    assign bus.ex_regdst    = idex_q.v & idex_q.regdst;
    assign bus.ex_aluop     = idex_q.v & idex_q.aluop;
    assign bus.ex_alusrc    = idex_q.v & idex_q.alusrc;
    assign bus.ex_rs        = idex_q.rs;
    assign bus.ex_rt        = idex_q.rt;
    assign bus.ex_dest      = ex_dest_w;

    assign bus.mem_branch   = exmem_q.v & exmem_q.branch;
    assign bus.mem_memread  = exmem_q.v & exmem_q.memread;
    assign bus.mem_memwrite = exmem_q.v & exmem_q.memwrite;
    assign bus.mem_dest     = exmem_q.dest;

    assign bus.wb_regwrite  = memwb_q.v & memwb_q.regwrite;
    assign bus.wb_memtoreg  = memwb_q.v & memwb_q.memtoreg;
    assign bus.wb_dest      = memwb_q.dest;

endmodule

// File: tb/tb_pipe_ctrl_carrier.sv
// Bench for pipe_ctrl_carrier: directed hazard programs plus random
// stimulus against an instruction-record pipeline model.
module tb_pipe_ctrl_carrier;
    localparam int RA_W = 5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipe_ctrl_carrier_if #(.RA_W(RA_W)) bus ();

    pipe_ctrl_carrier #(.RA_W(RA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic [2:0] ex;
        logic [2:0] m;
        logic [1:0] wb;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
    } ins_t;

    typedef struct {
        bit       regdst, aluop, alusrc;
        bit       branch, memread, memwrite;
        bit       regwrite, memtoreg;
        bit [4:0] rs, rt, rd, dest;
    } rec_t;

    rec_t m_ex, m_mem, m_wb;

    function automatic rec_t bubble();
        rec_t r;
        r = '{default: '0};
        return r;
    endfunction

    function automatic ins_t rtype(int rd, int rs, int rt);
        ins_t i;
        i.ex = 3'b110; i.m = 3'b000; i.wb = 2'b10;
        i.rs = 5'(rs); i.rt = 5'(rt); i.rd = 5'(rd);
        return i;
    endfunction

    function automatic ins_t lw(int rt, int rs);
        ins_t i;
        i.ex = 3'b001; i.m = 3'b010; i.wb = 2'b11;
        i.rs = 5'(rs); i.rt = 5'(rt); i.rd = 5'd0;
        return i;
    endfunction

    function automatic rec_t newrec();
        rec_t r;
        r = bubble();
        r.rs = bus.id_rs; r.rt = bus.id_rt; r.rd = bus.id_rd;
        if (bus.id_valid) begin
            {r.regdst, r.aluop, r.alusrc} = bus.id_ex;
            {r.branch, r.memread, r.memwrite} = bus.id_m;
            {r.regwrite, r.memtoreg} = bus.id_wb;
        end
        r.dest = r.regdst ? r.rd : r.rt;
        return r;
    endfunction

    function automatic bit writes(rec_t r);
        return r.regwrite && r.dest != 0;
    endfunction

    function automatic bit needs(rec_t r);
        return writes(r) && bus.id_valid &&
               (r.dest == bus.id_rs || r.dest == bus.id_rt);
    endfunction

    function automatic bit m_hazard();
`ifdef FORWARD_EN
        return m_ex.memread && needs(m_ex);
`else
        return needs(m_ex) || needs(m_mem);
`endif
    endfunction

    function automatic bit m_stall();
        return bus.mem_wait || (!bus.flush && m_hazard());
    endfunction

    function automatic bit [1:0] m_fwd(bit [4:0] a);
`ifdef FORWARD_EN
        if (writes(m_mem) && m_mem.dest == a) return 2'b10;
        if (writes(m_wb) && m_wb.dest == a) return 2'b01;
`endif
        return 2'b00;
    endfunction

    function automatic logic [37:0] m_vec();
        return {m_stall(), m_ex.regdst, m_ex.aluop, m_ex.alusrc,
                m_ex.rs, m_ex.rt, m_ex.dest,
                m_mem.branch, m_mem.memread, m_mem.memwrite, m_mem.dest,
                m_wb.regwrite, m_wb.memtoreg, m_wb.dest,
                m_fwd(m_ex.rs), m_fwd(m_ex.rt)};
    endfunction

    function automatic logic [37:0] dut_vec();
        return {bus.stall_out, bus.ex_regdst, bus.ex_aluop, bus.ex_alusrc,
                bus.ex_rs, bus.ex_rt, bus.ex_dest,
                bus.mem_branch, bus.mem_memread, bus.mem_memwrite,
                bus.mem_dest,
                bus.wb_regwrite, bus.wb_memtoreg, bus.wb_dest,
                bus.fwd_a, bus.fwd_b};
    endfunction

    task automatic tick();
        rec_t nex, nmem, nwb;
        nex = m_ex; nmem = m_mem; nwb = m_wb;
        if (rst) begin
            nex = bubble(); nmem = bubble(); nwb = bubble();
        end else if (!bus.mem_wait) begin
            nwb  = m_mem;
            nmem = bus.flush ? bubble() : m_ex;
            nex  = (bus.flush || m_hazard()) ? bubble() : newrec();
        end
        @(posedge clk);
        #1;
        m_ex = nex; m_mem = nmem; m_wb = nwb;
    endtask

    task automatic drive(ins_t i, bit v);
        bus.id_ex = i.ex; bus.id_m = i.m; bus.id_wb = i.wb;
        bus.id_rs = i.rs; bus.id_rt = i.rt; bus.id_rd = i.rd;
        bus.id_valid = v;
    endtask

    task automatic drive_rand(bit v);
        ins_t i;
        i.ex = 3'($urandom); i.m = 3'($urandom); i.wb = 2'($urandom);
        i.rs = 5'($urandom_range(0, 3));
        i.rt = 5'($urandom_range(0, 3));
        i.rd = 5'($urandom_range(0, 3));
        drive(i, v);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.flush = 1'b0; bus.mem_wait = 1'b0;
        drive_rand(1'($urandom));
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic run_prog(input ins_t prog[4], input int n,
                            input int tgt, input string nm,
                            output int stalls,
                            output logic [1:0] fa, output logic [1:0] fb);
        int  pc;
        bit  in_ex, rec_next, adv;
        logic [37:0] got, exp;
        ins_t nop;
        nop = '0;
        pc = 0; stalls = 0; fa = 2'bxx; fb = 2'bxx; in_ex = 0;
        do_reset();
        for (int c = 0; c < 16; c++) begin
            if (pc < n) drive(prog[pc], 1'b1);
            else drive(nop, 1'b0);
            bus.flush = 1'b0; bus.mem_wait = 1'b0;
            #1;
            got = dut_vec(); exp = m_vec();
            n_chk++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL %s_cycle%0d got=%h exp=%h", nm, c, got, exp);
            end
            if (in_ex) begin
                fa = bus.fwd_a; fb = bus.fwd_b;
            end
            if (bus.stall_out === 1'b1) stalls++;
            adv = (pc < n) && !m_stall();
            rec_next = adv && (pc == tgt);
            tick();
            if (adv) pc++;
            in_ex = rec_next;
        end
        n_chk++;
        if (pc != n) begin
            n_fail++;
            $display("FAIL %s_issue got=%0d exp=%0d", nm, pc, n);
        end
    endtask

    task automatic check_prog(string nm, int st, logic [1:0] fa,
                              logic [1:0] fb, int est,
                              logic [1:0] efa, logic [1:0] efb);
        n_chk++;
        if (st != est) begin
            n_fail++;
            $display("FAIL %s_stalls got=%0d exp=%0d", nm, st, est);
        end
        n_chk++;
        if (fa !== efa) begin
            n_fail++;
            $display("FAIL %s_fwd_a got=%b exp=%b", nm, fa, efa);
        end
        n_chk++;
        if (fb !== efb) begin
            n_fail++;
            $display("FAIL %s_fwd_b got=%b exp=%b", nm, fb, efb);
        end
    endtask

    task automatic test_reset();
        logic [37:0] got;
        m_ex = bubble(); m_mem = bubble(); m_wb = bubble();
        do_reset();
        drive_rand(1'b1);
        #1;
        got = dut_vec();
        n_chk++;
        if (got !== 38'd0) begin
            n_fail++;
            $display("FAIL reset_outputs got=%h exp=0", got);
        end
        n_chk++;
        if (bus.stall_out !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_stall got=%b exp=0", bus.stall_out);
        end
    endtask

    task automatic test_raw_alu();
        ins_t p[4];
        int st; logic [1:0] fa, fb;
        p[0] = rtype(3, 1, 2); p[1] = rtype(4, 3, 2);
        p[2] = '0; p[3] = '0;
        run_prog(p, 2, 1, "raw_alu", st, fa, fb);
`ifdef FORWARD_EN
        check_prog("raw_alu", st, fa, fb, 0, 2'b10, 2'b00);
`else
        check_prog("raw_alu", st, fa, fb, 2, 2'b00, 2'b00);
`endif
    endtask

    task automatic test_load_use();
        ins_t p[4];
        int st; logic [1:0] fa, fb;
        p[0] = lw(5, 1); p[1] = rtype(6, 2, 5);
        p[2] = '0; p[3] = '0;
        run_prog(p, 2, 1, "load_use", st, fa, fb);
`ifdef FORWARD_EN
        check_prog("load_use", st, fa, fb, 1, 2'b00, 2'b01);
`else
        check_prog("load_use", st, fa, fb, 2, 2'b00, 2'b00);
`endif
    endtask

    task automatic test_zero_reg();
        ins_t p[4];
        int st; logic [1:0] fa, fb;
        p[0] = rtype(0, 1, 2); p[1] = rtype(4, 0, 0);
        p[2] = '0; p[3] = '0;
        run_prog(p, 2, 1, "zero_reg", st, fa, fb);
        check_prog("zero_reg", st, fa, fb, 0, 2'b00, 2'b00);
    endtask

    task automatic test_mem_wait_flush();
        logic [37:0] got, exp, snap;
        ins_t i;
        do_reset();
        for (int c = 0; c < 3; c++) begin
            i = rtype(c + 8, c + 1, c + 2);
            i.ex = 3'b111; i.m = 3'($urandom_range(1, 7));
            drive(i, 1'b1);
            tick();
        end
        snap = m_vec();
        for (int c = 0; c < 3; c++) begin
            bus.mem_wait = 1'b1;
            bus.flush = (c == 1);
            drive_rand(1'b1);
            #1;
            got = dut_vec(); exp = m_vec();
            n_chk++;
            if (got[36:0] !== snap[36:0] || got !== exp) begin
                n_fail++;
                $display("FAIL freeze_c%0d got=%h exp=%h", c, got, exp);
            end
            n_chk++;
            if (bus.stall_out !== 1'b1) begin
                n_fail++;
                $display("FAIL freeze_stall_c%0d got=%b exp=1",
                         c, bus.stall_out);
            end
            tick();
        end
        bus.mem_wait = 1'b0; bus.flush = 1'b1;
        #1;
        n_chk++;
        if (bus.stall_out !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_stall got=%b exp=0", bus.stall_out);
        end
        tick();
        bus.flush = 1'b0;
        drive_rand(1'b0);
        #1;
        got = dut_vec(); exp = m_vec();
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL flush_state got=%h exp=%h", got, exp);
        end
        n_chk++;
        if ({bus.ex_regdst, bus.ex_aluop, bus.ex_alusrc, bus.mem_branch,
             bus.mem_memread, bus.mem_memwrite} !== 6'd0) begin
            n_fail++;
            $display("FAIL flush_ctrl got=%b%b%b%b%b%b exp=000000",
                     bus.ex_regdst, bus.ex_aluop, bus.ex_alusrc,
                     bus.mem_branch, bus.mem_memread, bus.mem_memwrite);
        end
    endtask

    task automatic test_random();
        logic [37:0] got, exp;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            rst = ($urandom_range(0, 49) == 0);
            bus.flush = ($urandom_range(0, 9) == 0);
            bus.mem_wait = ($urandom_range(0, 9) == 0);
            drive_rand(1'($urandom_range(0, 3) != 0));
            #1;
            got = dut_vec(); exp = m_vec();
            n_chk++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL random_c%0d got=%h exp=%h", c, got, exp);
            end
            tick();
        end
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        bus.flush = 1'b0;
        bus.mem_wait = 1'b0;
        drive_rand(1'b0);
        test_reset();
        test_raw_alu();
        test_load_use();
        test_zero_reg();
        test_mem_wait_flush();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
